lsu_mem_access: RTL
===================

// Module: lsu_mem_access
// PURPOSE
//  Load/store unit directly downstream of the execute ALU. Takes the ALU byte address plus rs2 and funct_3,
//  runs a req/gnt/rvalid handshake with data memory, builds byte enables/store lanes, sign/zero-extends load
//  data and presents a one-cycle writeback pulse. Stalls the pipeline while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  default 64  cycles in REQ or WAIT without gnt/rvalid before err_timeout fires (>=2)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  in_valid      in   1   EX presents a memory op this cycle
//  in_is_load    in   1   op is OP_LD (exclusive with in_is_store)
//  in_is_store   in   1   op is OP_ST
//  in_funct_3    in   3   LB/LH/LW/LBU/LHU or SB/SH/SW encoding
//  in_addr       in   32  byte address from ALU out
//  in_wdata      in   32  rs2 value for stores
//  in_rd         in   5   destination register for loads
//  in_ready      out  1   1 only in IDLE; EX holds its op while 0
//  mem_req       out  1   request to data memory
//  mem_we        out  1   1 = store
//  mem_addr      out  30  word address (byte addr [31:2])
//  mem_be        out  4   byte enables
//  mem_wdata     out  32  lane-replicated store data
//  mem_gnt       in   1   memory accepts request this cycle
//  mem_rvalid    in   1   load data valid; never earlier than the cycle after gnt
//  mem_rdata     in   32  raw load word
//  wb_valid      out  1   one-cycle pulse: load result ready
//  wb_rd         out  5   destination register
//  wb_data       out  32  extended load result
//  done          out  1   one-cycle pulse: any op (load/store/error) retired
//  err_illegal   out  1   one-cycle pulse: reserved funct_3
//  err_timeout   out  1   one-cycle pulse: handshake timeout
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; all other outputs 0; timeout counter 0. Reset mid-transaction aborts it,
//   drops mem_req immediately; a later stray mem_rvalid in IDLE is ignored.
//  FSM IDLE -> REQ -> (store) IDLE | (load) WAIT -> IDLE. Accept = in_valid & in_ready & (load|store).
//  IDLE: on accept, register addr/be/wdata/rd/funct_3; next cycle REQ. Reserved funct_3 (load 011/110/111,
//   store 011..111): no request, err_illegal+done next cycle, stay IDLE.
//  REQ: mem_req=1 with stable addr/we/be/wdata until mem_gnt. gnt on store -> done pulse, IDLE.
//   gnt on load -> WAIT. mem_rvalid in REQ ignored.
//  WAIT: on mem_rvalid, wb_valid+done pulse next cycle with wb_data/wb_rd; IDLE. Min load latency 3 cycles
//   accept->wb_valid (gnt and rvalid each on first eligible cycle); store 2 cycles accept->done.
//  Timeout: counter clears on entering REQ/WAIT, increments each cycle there; at TIMEOUT_CYCLES-1 without
//   the awaited signal -> err_timeout+done, mem_req dropped, IDLE.
//  Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}};
//   SW be=1111, wdata=rs2. Loads drive mem_be=1111.
//  Load extend: select byte addr[1:0] / half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass.
//  wb_data/wb_rd hold last value between pulses; outputs registered.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request;
//   err_misalign (extra out, 1) + done pulse next cycle, stay IDLE.
//  Undefined: no err_misalign port; offending low address bits ignored (half uses addr[1], word 00).
// STRUCTURE
//  Package lsu_pkg: lsu_state_t enum {IDLE,REQ,WAIT}; funct_3 constants for load/store widths (matching inst_defs.sv).
//  Sub-module load_extend (comb): funct_3, addr[1:0], rdata -> wb_data; reused by any future cache path.
// TESTING
//  SW addr 0x100 rs2 0xDEADBEEF, gnt 1st cycle -> mem_addr 0x40, be 1111, done 2 cycles after accept.
//  SB addr 0x103 rs2 0x000000A5 -> be 1000, wdata 0xA5A5A5A5; SH addr 0x102 -> be 1100.
//  LB addr 0x201 rdata 0x0000_8000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 rdata 0xBEEF0000 -> 0x0000BEEF.
//  gnt withheld 5 cycles then rvalid 3 later -> mem_req stable throughout, in_ready=0, single wb_valid.
//  No gnt for TIMEOUT_CYCLES -> err_timeout+done once, mem_req low, in_ready=1 next cycle.
//  reset_n low while in WAIT, then rvalid -> no wb_valid; LH addr 0x101 with MISALIGN_TRAP_EN -> err_misalign, no mem_req.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared state encoding and funct_3 width encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) return f3 inside {F3_SB, F3_SH, F3_SW};
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface lsu_mem_access_if;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_access_load_extend.sv
// Load data lane select and sign/zero extension; purely combinational.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct_3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct_3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LH:   data = {{16{h[15]}}, h};
            F3_LBU:  data = {24'd0, b};
            F3_LHU:  data = {16'd0, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: memory handshake, store lanes, load extension, writeback pulse.
// Optional MISALIGN_TRAP_EN adds err_misalign and traps misaligned half/word ops.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct_3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        in_ready,
    lsu_mem_access_if.master mem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_illegal,
    output logic        err_timeout
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        err_misalign
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [3:0]    be_q, be_d;
    logic [4:0]    rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [2:0]    f3_q, f3_d;
    logic          we_q, we_d;
    logic          wb_valid_q, wb_valid_d, done_q, done_d;
    logic          ill_q, ill_d, to_q, to_d;
`ifdef MISALIGN_TRAP_EN
    logic          mis_q, mis_d;
`endif

    logic        accept, illegal, misalign;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ext_data;

    assign accept  = in_valid && in_ready && (in_is_load || in_is_store);
    assign illegal = !f3_legal(in_is_store, in_funct_3);
`ifdef MISALIGN_TRAP_EN
    assign misalign = (in_funct_3[1:0] == 2'b01 && in_addr[0]) ||
                      (in_funct_3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Without the trap, half lanes follow addr[1] and words ignore addr[1:0].
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = in_wdata;
        if (in_is_store) begin
            case (in_funct_3[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << in_addr[1:0];
                    lane_wdata = {4{in_wdata[7:0]}};
                end
                2'b01: begin
                    lane_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{in_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_extend u_ext (
        .funct_3 (f3_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (mem.rdata),
        .data    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        we_d       = we_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        ill_d      = 1'b0;
        to_d       = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d      = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) begin
                if (illegal) begin
                    ill_d  = 1'b1;
                    done_d = 1'b1;
                end else if (misalign) begin
`ifdef MISALIGN_TRAP_EN
                    mis_d  = 1'b1;
`endif
                    done_d = 1'b1;
                end else begin
                    addr_d  = in_addr;
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    rd_d    = in_rd;
                    f3_d    = in_funct_3;
                    we_d    = in_is_store;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (mem.rvalid) begin
                    wb_valid_d = 1'b1;
                    done_d     = 1'b1;
                    wb_data_d  = ext_data;
                    wb_rd_d    = rd_q;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ill_q      <= 1'b0;
            to_q       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            ill_q      <= ill_d;
            to_q       <= to_d;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign mem.req     = (state_q == REQ);
    assign mem.we      = we_q;
    assign mem.addr    = addr_q[31:2];
    assign mem.be      = be_q;
    assign mem.wdata   = wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign done        = done_q;
    assign err_illegal = ill_q;
    assign err_timeout = to_q;
`ifdef MISALIGN_TRAP_EN
    assign err_misalign = mis_q;
`endif

endmodule
